// File: rtl/mult_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : mult_rr_sched
// Description : Two-requester shift-add multiplier with round-robin grant.
//               Define MULT_ZERO_SKIP_EN to finish zero-operand ops at once.
// Revision    : 1.0  initial release
// ============================================================================
module mult_rr_sched #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           req1_ready,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*W-1:0] rsp_prod,
    output logic           rsp_id,
    output logic           busy
);

    localparam int              c_CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(W - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      r_state;
    logic            r_last;
    logic            r_id;
    logic [2*W-1:0]  r_mcand;
    logic [2*W-1:0]  r_acc;
    logic [W-1:0]    r_mplier;
    logic [c_CW-1:0] r_cnt;

    logic            w_idle;
    logic            w_gnt0;
    logic            w_gnt1;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic            w_zero;

    // r_last holds the index granted most recently; the other side wins a tie.
    assign w_idle = (r_state == c_IDLE) && !rst;
    assign w_gnt0 = w_idle && req0_valid && (!req1_valid || r_last);
    assign w_gnt1 = w_idle && req1_valid && (!req0_valid || !r_last);
    assign w_a    = w_gnt1 ? req1_a : req0_a;
    assign w_b    = w_gnt1 ? req1_b : req0_b;

`ifdef MULT_ZERO_SKIP_EN
    assign w_zero = (w_a == '0) || (w_b == '0);
`else
    assign w_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_last   <= 1'b1;
            r_id     <= 1'b0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_mcand  <= {{W{1'b0}}, w_a};
                        r_mplier <= w_b;
                        r_acc    <= '0;
                        r_id     <= w_gnt1;
                        r_last   <= w_gnt1;
                        r_cnt    <= '0;
                        r_state  <= w_zero ? c_DONE : c_CALC;
                    end
                end
                c_CALC: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (rsp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp_valid  = (r_state == c_DONE);
    assign rsp_prod   = rsp_valid ? r_acc : '0;
    assign rsp_id     = rsp_valid & r_id;
    assign busy       = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_rr_sched
// Description : Directed self-checking bench for mult_rr_sched (W = 4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_mult_rr_sched;

    localparam int W = 4;
`ifdef MULT_ZERO_SKIP_EN
    localparam int c_ZLAT = 0;
`else
    localparam int c_ZLAT = 4;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req1_valid;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           req0_ready, req1_ready;
    logic           rsp_valid, rsp_ready;
    logic [2*W-1:0] rsp_prod;
    logic           rsp_id;
    logic           busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mult_rr_sched #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_prod   (rsp_prod),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge; walks W calc edges, checks response.
    task automatic finish_op(input string tag, input int exp_prod, input int exp_id);
        for (int i = 0; i < W; i++) begin
            check({tag, "_novalid"}, 32'(rsp_valid), 0);
            tick();
        end
        check({tag, "_valid"}, 32'(rsp_valid), 1);
        check({tag, "_prod"},  32'(rsp_prod), 32'(exp_prod));
        check({tag, "_id"},    32'(rsp_id), 32'(exp_id));
    endtask

    int r0v[5] = '{1, 1, 0, 1, 1};
    int gnt[5] = '{1, 0, 1, 0, 1};

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd13; req0_b = 4'd11;
        req1_valid = 1'b0; req1_a = '0;    req1_b = '0;
        #2;
        check("rst_busy",   32'(busy), 0);
        check("rst_valid",  32'(rsp_valid), 0);
        check("rst_prod",   32'(rsp_prod), 0);
        check("rst_id",     32'(rsp_id), 0);
        check("rst_ready0", 32'(req0_ready), 0);
        check("rst_ready1", 32'(req1_ready), 0);

        // Lone requester 0: 13*11
        tick();
        rst = 1'b0;
        #1;
        check("t1_ready0", 32'(req0_ready), 1);
        tick();
        req0_valid = 1'b0;
        check("t1_ready0_drop", 32'(req0_ready), 0);
        check("t1_busy", 32'(busy), 1);
        finish_op("t1", 143, 0);
        tick();
        check("t1_idle_busy",  32'(busy), 0);
        check("t1_idle_valid", 32'(rsp_valid), 0);
        check("t1_idle_prod",  32'(rsp_prod), 0);

        // Both valid from reset: req0 wins first tie
        rst = 1'b1; #2; rst = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd3;  req0_b = 4'd5;
        req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15;
        #1;
        check("t2_ready0", 32'(req0_ready), 1);
        check("t2_ready1", 32'(req1_ready), 0);
        tick();
        req0_valid = 1'b0;
        check("t2_calc_ready1", 32'(req1_ready), 0);
        finish_op("t2a", 15, 0);
        check("t2_done_ready1", 32'(req1_ready), 0);
        tick();
        check("t2_idle_ready1", 32'(req1_ready), 1);
        check("t2_idle_valid", 32'(rsp_valid), 0);
        tick();
        req1_valid = 1'b0;
        finish_op("t2b", 225, 1);
        tick();

        // Back-pressure: 7*9 held while rsp_ready low
        req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd9;
        rsp_ready = 1'b0;
        #1;
        check("t3_ready0", 32'(req0_ready), 1);
        tick();
        req0_valid = 1'b0;
        finish_op("t3", 63, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_hold_valid",  32'(rsp_valid), 1);
            check("t3_hold_prod",   32'(rsp_prod), 63);
            check("t3_hold_busy",   32'(busy), 1);
            check("t3_hold_ready0", 32'(req0_ready), 0);
            check("t3_hold_ready1", 32'(req1_ready), 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("t3_release_busy", 32'(busy), 0);

        // Reset mid-calc discards 9*9
        req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd9;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t4_rst_busy",  32'(busy), 0);
        check("t4_rst_valid", 32'(rsp_valid), 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_no_rsp", 32'(rsp_valid), 0);
        end
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd6;
        tick();
        req0_valid = 1'b0;
        finish_op("t4", 12, 0);
        tick();

        // Zero operand latency
        req0_valid = 1'b1; req0_a = 4'd0; req0_b = 4'd12;
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < c_ZLAT; i++) begin
            check("t5_novalid", 32'(rsp_valid), 0);
            tick();
        end
        check("t5_valid", 32'(rsp_valid), 1);
        check("t5_prod",  32'(rsp_prod), 0);
        tick();

        // Fairness: req1 always valid, req0 pulses
        req0_a = 4'd2; req0_b = 4'd3;
        req1_a = 4'd5; req1_b = 4'd5;
        req1_valid = 1'b1;
        for (int r = 0; r < 5; r++) begin
            req0_valid = r0v[r][0];
            #1;
            check("t6_ready0", 32'(req0_ready), (gnt[r] == 0) ? 1 : 0);
            check("t6_ready1", 32'(req1_ready), (gnt[r] == 1) ? 1 : 0);
            tick();
            req0_valid = 1'b0;
            finish_op("t6", (gnt[r] == 1) ? 25 : 6, gnt[r]);
            tick();
        end
        req1_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
